// File: rtl/pitch_shift_pkg.sv
// Shared widths and state encodings for the FFT-to-resampler frame controller.
package pitch_shift_pkg;

  localparam int N_WIDTH_DEFAULT = 12;
  localparam int SF_INT_DEFAULT  = 4;
  localparam int SF_FRAC_DEFAULT = 5;
  localparam int SFW             = SF_INT_DEFAULT + SF_FRAC_DEFAULT;
  localparam int NUM_BANKS       = 2;

  localparam logic [SFW-1:0] UNITY_SCALE = SFW'(1) << SF_FRAC_DEFAULT;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    WR_SYNC = 2'd0,
    WR_IDLE = 2'd1,
    WR_FILL = 2'd2,
    WR_DROP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_START = 2'd1,
    RD_RUN   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/resampler_frame_ctrl_if.sv
// FFT beat input, spectrum RAM write port and resampler handshake of the frame controller.
interface resampler_frame_ctrl_if #(
  parameter int N_WIDTH = 12,
  parameter int SFW     = 9
);
  logic [SFW-1:0]     scale_factor;
  logic               scale_factor_valid;
  logic               fft_valid;
  logic               fft_last;
  logic               wr_enable;
  logic               wr_bank;
  logic [N_WIDTH-1:0] wr_addr;
  logic               rs_start;
  logic               rs_bank;
  logic [SFW-1:0]     rs_scale_factor;
  logic               rs_done;
  logic               overrun;
  logic               length_error;

  modport master (
    input  scale_factor, scale_factor_valid, fft_valid, fft_last, rs_done,
    output wr_enable, wr_bank, wr_addr, rs_start, rs_bank, rs_scale_factor,
           overrun, length_error
  );

  modport slave (
    output scale_factor, scale_factor_valid, fft_valid, fft_last, rs_done,
    input  wr_enable, wr_bank, wr_addr, rs_start, rs_bank, rs_scale_factor,
           overrun, length_error
  );
endinterface

// File: rtl/resampler_frame_ctrl_pingpong_bank_tracker.sv
// Per-bank EMPTY/FILLING/FULL/READING tracking for the two-bank spectrum RAM.
module pingpong_bank_tracker
  import pitch_shift_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic fill_start,
  input  logic fill_done,
  input  logic fill_bank,
  input  logic start_read,
  input  logic read_release,
  input  logic rd_bank,
  output logic is_free,
  output logic rd_full
);

  bank_state_t bank_state [NUM_BANKS];

  // A bank released this cycle counts as free so a frame starting on the same edge can claim it.
  assign is_free = (bank_state[fill_bank] == BANK_EMPTY) ||
                   (read_release && (rd_bank == fill_bank));
  assign rd_full = (bank_state[rd_bank] == BANK_FULL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_state[b] <= BANK_EMPTY;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (fill_done && (fill_bank == b[0]))
          bank_state[b] <= BANK_FULL;
        else if (fill_start && (fill_bank == b[0]))
          bank_state[b] <= BANK_FILLING;
        else if (start_read && (rd_bank == b[0]))
          bank_state[b] <= BANK_READING;
        else if (read_release && (rd_bank == b[0]))
          bank_state[b] <= BANK_EMPTY;
      end
    end
  end

endmodule

// File: rtl/resampler_frame_ctrl.sv
// Frame controller between FFT output and resampler: ping-pong bank steering,
// per-pass scale-factor freeze and whole-frame drop on overrun.
//
// writer state | meaning
// WR_SYNC      | after reset, discard beats up to the first fft_last
// WR_IDLE      | between frames, first beat claims wr_bank if free
// WR_FILL      | writing beats into wr_bank
// WR_DROP      | write bank busy, discarding the rest of the frame
// reader state | meaning
// RD_IDLE      | wait for rs_bank FULL and a scale factor seen
// RD_START     | rs_start pulse cycle, bank marked READING
// RD_RUN       | resampler pass active, wait for rs_done
module resampler_frame_ctrl
  import pitch_shift_pkg::*;
#(
  parameter int N_WIDTH                     = N_WIDTH_DEFAULT,
  parameter int SCALE_FACTOR_INTEGER_WIDTH  = SF_INT_DEFAULT,
  parameter int SCALE_FACTOR_FRACTION_WIDTH = SF_FRAC_DEFAULT
) (
  input logic                    clock,
  input logic                    reset_n,
  resampler_frame_ctrl_if.master bus
);

  localparam int SF_W = SCALE_FACTOR_INTEGER_WIDTH + SCALE_FACTOR_FRACTION_WIDTH;
  localparam logic [N_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [SF_W-1:0]    SF_UNITY = SF_W'(1) << SCALE_FACTOR_FRACTION_WIDTH;

  wr_state_t          wr_state;
  logic [N_WIDTH-1:0] wr_addr_q;
  logic               wr_bank_q;
  logic               overrun_q;
  logic               length_error_q;

  rd_state_t          rd_state;
  logic               rs_start_q;
  logic               rs_bank_q;
  logic [SF_W-1:0]    rs_sf_q;
  logic [SF_W-1:0]    pending_sf;
  logic               sf_seen;

  logic is_free, rd_full, beat_last, wr_en;
  logic fill_start, fill_done, start_read, read_release;

  assign beat_last    = bus.fft_valid & bus.fft_last;
  assign wr_en        = bus.fft_valid &
                        ((wr_state == WR_FILL) | ((wr_state == WR_IDLE) & is_free));
  assign fill_start   = wr_en & (wr_state == WR_IDLE);
  assign fill_done    = wr_en & bus.fft_last;
  assign start_read   = (rd_state == RD_START);
  assign read_release = (rd_state == RD_RUN) & bus.rs_done;

  pingpong_bank_tracker u_tracker (
    .clock        (clock),
    .reset_n      (reset_n),
    .fill_start   (fill_start),
    .fill_done    (fill_done),
    .fill_bank    (wr_bank_q),
    .start_read   (start_read),
    .read_release (read_release),
    .rd_bank      (rs_bank_q),
    .is_free      (is_free),
    .rd_full      (rd_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_state       <= WR_SYNC;
      wr_addr_q      <= '0;
      wr_bank_q      <= 1'b0;
      overrun_q      <= 1'b0;
      length_error_q <= 1'b0;
    end else begin
      overrun_q      <= 1'b0;
      length_error_q <= 1'b0;
      if (wr_en) begin
        if (bus.fft_last) begin
          length_error_q <= (wr_addr_q != ADDR_MAX);
          wr_addr_q      <= '0;
          wr_bank_q      <= ~wr_bank_q;
          wr_state       <= WR_IDLE;
        end else begin
          wr_addr_q <= wr_addr_q + 1'b1;
          wr_state  <= WR_FILL;
        end
      end else begin
        case (wr_state)
          WR_SYNC: if (beat_last) wr_state <= WR_IDLE;
          WR_IDLE: begin
            // Reaching here with a beat means the write bank is still busy.
            if (beat_last)            overrun_q <= 1'b1;
            else if (bus.fft_valid)   wr_state  <= WR_DROP;
          end
          WR_FILL: ;
          WR_DROP: begin
            if (beat_last) begin
              overrun_q <= 1'b1;
              wr_state  <= WR_IDLE;
            end
          end
          default: wr_state <= WR_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_sf <= SF_UNITY;
      sf_seen    <= 1'b0;
    end else if (bus.scale_factor_valid) begin
      pending_sf <= bus.scale_factor;
      sf_seen    <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_state   <= RD_IDLE;
      rs_start_q <= 1'b0;
      rs_bank_q  <= 1'b0;
      rs_sf_q    <= '0;
    end else begin
      rs_start_q <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (rd_full && sf_seen) begin
            rd_state   <= RD_START;
            rs_start_q <= 1'b1;
            rs_sf_q    <= pending_sf;
          end
        end
        RD_START: rd_state <= RD_RUN;
        RD_RUN: begin
          if (bus.rs_done) begin
            rs_bank_q <= ~rs_bank_q;
            rd_state  <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign bus.wr_enable       = wr_en;
  assign bus.wr_bank         = wr_bank_q;
  assign bus.wr_addr         = wr_addr_q;
  assign bus.overrun         = overrun_q;
  assign bus.length_error    = length_error_q;
  assign bus.rs_start        = rs_start_q;
  assign bus.rs_bank         = rs_bank_q;
  assign bus.rs_scale_factor = rs_sf_q;

endmodule
